// File: rtl/borrow_skip_subtractor_seq_pkg.sv
// Shared definitions for the sequential borrow-skip subtractor: FSM encoding and block sizing.
package borrow_skip_subtractor_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;
    localparam int NBLK      = DEF_WIDTH / DEF_BLK;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int nblk_of(input int width, input int blk);
        return width / blk;
    endfunction

    // Wide enough to count every block as skipped, including the all-blocks case.
    function automatic int skip_cnt_w(input int width, input int blk);
        return $clog2(width / blk) + 1;
    endfunction

endpackage

// File: rtl/borrow_skip_subtractor_seq_if.sv
// Operand/result handshake bundle for the borrow-skip subtractor.
// The ovf signal exists only when BSKIP_OVF_EN is defined.
interface borrow_skip_subtractor_seq_if
    import borrow_skip_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
);
    localparam int CNTW = skip_cnt_w(WIDTH, BLK);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [CNTW-1:0]  skip_cnt;
`ifdef BSKIP_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef BSKIP_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef BSKIP_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout, skip_cnt
    );

endinterface

// File: rtl/borrow_skip_subtractor_seq_block.sv
// One BLK-bit slice: ripple subtract a_k - b_k - bin_i with a skip mux on the borrow-out.
module borrow_skip_block
    import borrow_skip_subtractor_seq_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a_k_i,
    input  logic [BLK-1:0] b_k_i,
    input  logic           bin_i,
    output logic [BLK-1:0] d_o,
    output logic           bout_o,
    output logic           skip_o
);
    logic brw;
    logic ripple_bout;

    always_comb begin
        brw = bin_i;
        d_o = '0;
        for (int i = 0; i < BLK; i++) begin
            d_o[i] = a_k_i[i] ^ b_k_i[i] ^ brw;
            brw    = (~a_k_i[i] & b_k_i[i]) | (~(a_k_i[i] ^ b_k_i[i]) & brw);
        end
        ripple_bout = brw;
    end

    // Equal operand bits everywhere: the borrow passes through unchanged.
    assign skip_o = &(~(a_k_i ^ b_k_i));
    assign bout_o = skip_o ? bin_i : ripple_bout;

endmodule

// File: rtl/borrow_skip_subtractor_seq.sv
// Multi-cycle a - b - bin, one BLK-bit block per clock, LSB block first, with skip counting.
// Define BSKIP_OVF_EN to add the signed-overflow flag.
module borrow_skip_subtractor_seq
    import borrow_skip_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic                         clk,
    input  logic                         rst,
    borrow_skip_subtractor_seq_if.slave  bus_if
);
    localparam int NB   = nblk_of(WIDTH, BLK);
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNTW = skip_cnt_w(WIDTH, BLK);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [CNTW-1:0]  skip_q, skip_d;
    logic [IDXW-1:0]  idx_q, idx_d;
`ifdef BSKIP_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [BLK-1:0]   blk_d;
    logic             blk_bout;
    logic             blk_skip;

    borrow_skip_block #(.BLK(BLK)) u_block (
        .a_k_i  (a_q[idx_q*BLK +: BLK]),
        .b_k_i  (b_q[idx_q*BLK +: BLK]),
        .bin_i  (brw_q),
        .d_o    (blk_d),
        .bout_o (blk_bout),
        .skip_o (blk_skip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            skip_q  <= '0;
            idx_q   <= '0;
`ifdef BSKIP_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            skip_q  <= skip_d;
            idx_q   <= idx_d;
`ifdef BSKIP_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        skip_d  = skip_q;
        idx_d   = idx_q;
`ifdef BSKIP_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus_if.in_valid) begin
                    a_d     = bus_if.a;
                    b_d     = bus_if.b;
                    brw_d   = bus_if.bin;
                    diff_d  = '0;
                    skip_d  = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[idx_q*BLK +: BLK] = blk_d;
                skip_d = skip_q + CNTW'(blk_skip);
                brw_d  = blk_bout;
                if (idx_q == IDXW'(NB - 1)) begin
                    bout_d  = blk_bout;
`ifdef BSKIP_OVF_EN
                    // Last block carries the result sign bit.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (blk_d[BLK-1] != a_q[WIDTH-1]);
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus_if.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.in_ready  = (state_q == S_IDLE);
    assign bus_if.out_valid = (state_q == S_DONE);
    assign bus_if.diff      = diff_q;
    assign bus_if.bout      = bout_q;
    assign bus_if.skip_cnt  = skip_q;
`ifdef BSKIP_OVF_EN
    assign bus_if.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Scoreboard bench for borrow_skip_subtractor_seq; ovf is checked when BSKIP_OVF_EN is defined.
`timescale 1ns/1ps
module tb_borrow_skip_subtractor_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    borrow_skip_subtractor_seq_if #(.WIDTH(16), .BLK(4)) bif ();

    borrow_skip_subtractor_seq #(.WIDTH(16), .BLK(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic [2:0]  skip;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on each result handshake, pop the expected entry and compare.
    always @(negedge clk) begin
        if (!rst && bif.out_valid && bif.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("diff", 32'(bif.diff), 32'(e.diff));
                chk("bout", 32'(bif.bout), 32'(e.bout));
                chk("skip_cnt", 32'(bif.skip_cnt), 32'(e.skip));
`ifdef BSKIP_OVF_EN
                chk("ovf", 32'(bif.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bif.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
        chk({tag, "_diff"}, 32'(bif.diff), 32'd0);
        chk({tag, "_bout"}, 32'(bif.bout), 32'd0);
        chk({tag, "_skip_cnt"}, 32'(bif.skip_cnt), 32'd0);
`ifdef BSKIP_OVF_EN
        chk({tag, "_ovf"}, 32'(bif.ovf), 32'd0);
`endif
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [15:0] ed, input logic eb, input logic [2:0] es,
                          input logic eo, input int hold);
        exp_t e;
        int   n;
        e.diff = ed; e.bout = eb; e.skip = es; e.ovf = eo;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bif.in_valid = 1'b1; bif.a = a; bif.b = b; bif.bin = bin; bif.out_ready = 1'b0;
        @(negedge clk);
        chk("accept_in_ready", 32'(bif.in_ready), 32'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.out_valid && n < 20);
        chk("latency", n, 32'd5);
        // Backpressure: results must hold while new operands are offered and refused.
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bif.in_valid = 1'b1; bif.a = 16'hFFFF; bif.b = 16'h0000; bif.bin = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", 32'(bif.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bif.in_ready), 32'd0);
            chk("hold_diff", 32'(bif.diff), 32'(ed));
            chk("hold_skip", 32'(bif.skip_cnt), 32'(es));
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0; bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 32'(bif.in_ready), 32'd1);
        chk("post_out_valid", 32'(bif.out_valid), 32'd0);
    endtask

    initial begin
        bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.bin = 1'b0; bif.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 3'd3, 1'b0, 6);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 3'd3, 1'b0, 0);
        run_op(16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 3'd4, 1'b0, 1);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 3'd2, 1'b1, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 3'd3, 1'b1, 0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 3'd4, 1'b0, 0);

        // Reset during RUN discards the operation entirely.
        @(posedge clk); #1;
        bif.in_valid = 1'b1; bif.a = 16'h4321; bif.b = 16'h1111; bif.bin = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrun");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_rst");

        run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 3'd3, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_tests);
        $fatal(1, "timeout");
    end

endmodule
